inst_fetch: RTL and testbench

Instruction-fetch front end sitting directly upstream of the instruction cache. It owns the PC and translates kseg0/kseg1 virtual addresses to physical ones. It issues one-word read requests to the cache and buffers returned instructions in a 2-entry FIFO feeding decode. It handles branch/exception redirects, including discarding a fetch that is still in flight.

---
 rtl/inst_fetch.sv | 161 ++++++++++++++++
 tb/tb_inst_fetch.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the PC, maps kseg0/kseg1 to physical
// addresses, issues one-word reads to the instruction cache, and buffers the
// returned instructions in a 2-entry FIFO that feeds decode. Redirects flush
// all younger work, including a fetch whose response is still in flight.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ic_araddr,
    output logic        ic_arvalid,
    output logic        ic_cache_ena,
    input  logic [31:0] ic_rdata,
    input  logic        ic_rvalid,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        id_adel
);

    typedef enum logic [1:0] {
        S_REQ,   // ready to issue a request for pc
        S_WAIT,  // request outstanding, response belongs to pc
        S_DROP,  // request outstanding, response is stale and discarded
        S_HALT   // misaligned pc reported, wait for a redirect
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;

    // FIFO storage and bookkeeping
    logic [31:0] fifo_pc   [2];
    logic [31:0] fifo_inst [2];
    logic        fifo_adel [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;

    logic        push, pop, fifo_full;
    logic [31:0] push_inst;
    logic        push_adel;

    assign fifo_full = (count == 2'd2);
    assign id_valid  = (count != 2'd0);
    // A redirect discards the head, so a simultaneous pop must not count.
    assign pop       = id_valid & id_ready & ~redirect;

    assign id_pc   = fifo_pc[rd_ptr];
    assign id_inst = fifo_inst[rd_ptr];
    assign id_adel = fifo_adel[rd_ptr];

    // kseg0 and kseg1 both drop the top three bits; kseg1 is uncached.
    assign ic_araddr    = (pc[31:30] == 2'b10) ? {3'b000, pc[28:0]} : pc;
    assign ic_cache_ena = (pc[31:29] != 3'b101);

    // Next-state, next-pc, request and push decisions for the fetch FSM.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        state_nxt = state;
        pc_nxt    = pc;
        // Held low during reset so no request escapes while the cache resets.
        ic_arvalid = 1'b0;
        push       = 1'b0;
        push_inst  = 32'h0;
        push_adel  = 1'b0;
        case (state)
            S_REQ: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end else if (fifo_full) begin
                    state_nxt = S_REQ;
                end else if (pc[1:0] != 2'b00) begin
                    push      = 1'b1;
                    push_adel = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    ic_arvalid = rst;
                    state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = ic_rvalid ? S_REQ : S_DROP;
                end else if (ic_rvalid) begin
                    push      = 1'b1;
                    push_inst = ic_rdata;
                    pc_nxt    = pc + 32'd4;
                    state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end
                if (ic_rvalid) begin
                    state_nxt = S_REQ;
                end
            end
            S_HALT: begin
                if (redirect) begin
                    pc_nxt    = redirect_pc;
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    // FSM state and pc registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst) begin
            state <= S_REQ;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // FIFO: push from the FSM, pop to decode, full flush on redirect.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the two entries are reset as well, because id_* read the
            // head directly and must show zero out of reset.
            for (int i = 0; i < 2; i++) begin
                fifo_pc[i]   <= 32'h0;
                fifo_inst[i] <= 32'h0;
                fifo_adel[i] <= 1'b0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (redirect) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]   <= pc;
                fifo_inst[wr_ptr] <= push_inst;
                fifo_adel[wr_ptr] <= push_adel;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a cache model with configurable latency,
// directed stimulus with hand-computed expectations, and a per-cycle
// behavioural model of the fetch stream compared on every falling edge.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ic_araddr;
    logic        ic_arvalid;
    logic        ic_cache_ena;
    logic [31:0] ic_rdata;
    logic        ic_rvalid;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_adel;

    int checks = 0;
    int errors = 0;
    int lat_cfg;

    inst_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .ic_araddr    (ic_araddr),
        .ic_arvalid   (ic_arvalid),
        .ic_cache_ena (ic_cache_ena),
        .ic_rdata     (ic_rdata),
        .ic_rvalid    (ic_rvalid),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_inst      (id_inst),
        .id_pc        (id_pc),
        .id_adel      (id_adel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory image seen through the cache: word value derived from its address.
    function automatic logic [31:0] mem_word(input logic [31:0] pa);
        return pa ^ 32'hDEAD_BEEF;
    endfunction

    // Virtual-to-physical: kseg0 sits at 0x8000_0000, kseg1 at 0xA000_0000.
    function automatic logic [31:0] phys(input logic [31:0] va);
        if (va >= 32'h8000_0000 && va < 32'hA000_0000) return va - 32'h8000_0000;
        if (va >= 32'hA000_0000 && va < 32'hC000_0000) return va - 32'hA000_0000;
        return va;
    endfunction

    // Cache model: accepts a request seen on a falling edge and answers after
    // lat_cfg cycles; reset drops anything pending.
    initial begin : cache_model
        logic        pend;
        logic [31:0] paddr;
        int          cnt;
        pend      = 1'b0;
        paddr     = 32'h0;
        cnt       = 0;
        ic_rvalid = 1'b0;
        ic_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0;
            end else if (ic_arvalid && !pend) begin
                pend  = 1'b1;
                paddr = ic_araddr;
                cnt   = lat_cfg;
            end
            @(posedge clk);
            #2;
            ic_rvalid = 1'b0;
            ic_rdata  = $urandom;
            if (pend) begin
                if (cnt <= 1) begin
                    ic_rvalid = 1'b1;
                    ic_rdata  = mem_word(paddr);
                    pend      = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Behavioural model: the decode stream after a redirect to X is X, X+4, ...
    // each carrying the memory word at its physical address; a fetch issued
    // before a redirect never contributes.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } entry_t;

    entry_t      q[$];
    logic [31:0] fetch_pc;
    logic        outstanding = 1'b0;
    logic        stale       = 1'b0;
    logic        halted      = 1'b0;
    logic        model_valid = 1'b0;

    // Compare the DUT against the model, then advance the model one cycle.
    always @(negedge clk) begin : compare
        int     sz;
        logic   exp_ar;
        logic   do_pop;
        entry_t e;
        sz = q.size();
        exp_ar = rst && !redirect && !outstanding && !halted && (sz < 2) &&
                 (fetch_pc[1:0] == 2'b00);
        if (model_valid) begin
            check("model_arvalid", {31'h0, ic_arvalid}, {31'h0, exp_ar});
            check("model_araddr", ic_araddr, phys(fetch_pc));
            check("model_cache_ena", {31'h0, ic_cache_ena},
                  {31'h0, (fetch_pc < 32'hA000_0000 || fetch_pc >= 32'hC000_0000)});
            check("model_id_valid", {31'h0, id_valid}, {31'h0, (sz != 0)});
            if (sz != 0) begin
                check("model_id_pc", id_pc, q[0].pc);
                check("model_id_inst", id_inst, q[0].inst);
                check("model_id_adel", {31'h0, id_adel}, {31'h0, q[0].adel});
            end
        end
        if (!rst) begin
            q.delete();
            fetch_pc    = 32'hBFC0_0000;
            outstanding = 1'b0;
            stale       = 1'b0;
            halted      = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            do_pop = (sz != 0) && id_ready && !redirect;
            if (redirect) begin
                q.delete();
                fetch_pc = redirect_pc;
                halted   = 1'b0;
                if (outstanding) begin
                    if (ic_rvalid) begin
                        outstanding = 1'b0;
                        stale       = 1'b0;
                    end else begin
                        stale = 1'b1;
                    end
                end
            end else begin
                if (do_pop) void'(q.pop_front());
                if (outstanding) begin
                    if (ic_rvalid) begin
                        if (!stale) begin
                            e.pc   = fetch_pc;
                            e.inst = mem_word(phys(fetch_pc));
                            e.adel = 1'b0;
                            q.push_back(e);
                            fetch_pc = fetch_pc + 32'd4;
                        end
                        outstanding = 1'b0;
                        stale       = 1'b0;
                    end
                end else if (!halted && sz < 2) begin
                    if (fetch_pc[1:0] == 2'b00) begin
                        outstanding = 1'b1;
                    end else begin
                        e.pc   = fetch_pc;
                        e.inst = 32'h0;
                        e.adel = 1'b1;
                        q.push_back(e);
                        halted = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_arvalid", {31'h0, ic_arvalid}, 32'h0);
        check("rst_araddr", ic_araddr, 32'h1FC0_0000);
        check("rst_cache_ena", {31'h0, ic_cache_ena}, 32'h0);
        check("rst_id_valid", {31'h0, id_valid}, 32'h0);
        check("rst_id_inst", id_inst, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_adel", {31'h0, id_adel}, 32'h0);
    endtask

    // Directed stimulus; cycle numbers count from the first cycle with rst high.
    initial begin
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b1;
        lat_cfg     = 1;

        repeat (3) tick();
        #2;
        check_reset_values();

        // Cycle 0: first request straight out of reset, uncached kseg1.
        tick(); rst = 1'b1; #2;
        check("c0_arvalid", {31'h0, ic_arvalid}, 32'h1);
        check("c0_araddr", ic_araddr, 32'h1FC0_0000);
        check("c0_cache_ena", {31'h0, ic_cache_ena}, 32'h0);

        tick(); tick(); #2;  // cycle 2
        check("c2_id_valid", {31'h0, id_valid}, 32'h1);
        check("c2_id_pc", id_pc, 32'hBFC0_0000);
        check("c2_id_inst", id_inst, 32'hC16D_BEEF);
        tick(); #2;          // cycle 3
        check("c3_id_valid", {31'h0, id_valid}, 32'h0);
        tick(); #2;          // cycle 4
        check("c4_id_pc", id_pc, 32'hBFC0_0004);
        id_ready = 1'b0;

        // Backpressure: two entries buffered, no further requests.
        repeat (10) tick();
        #2;                  // cycle 14
        check("c14_id_valid", {31'h0, id_valid}, 32'h1);
        check("c14_id_pc", id_pc, 32'hBFC0_0004);
        check("c14_arvalid", {31'h0, ic_arvalid}, 32'h0);
        id_ready = 1'b1;
        tick(); #2;          // cycle 15
        check("c15_id_pc", id_pc, 32'hBFC0_0008);
        check("c15_arvalid", {31'h0, ic_arvalid}, 32'h1);
        check("c15_araddr", ic_araddr, 32'h1FC0_000C);
        lat_cfg = 10;

        // Redirect one cycle after a miss; the stale response lands in cycle 25.
        tick(); redirect = 1'b1; redirect_pc = 32'h8000_1000;  // cycle 16
        tick(); redirect = 1'b0; lat_cfg = 1; #2;              // cycle 17
        for (int i = 0; i < 9; i++) begin
            check("drop_arvalid", {31'h0, ic_arvalid}, 32'h0);
            check("drop_id_valid", {31'h0, id_valid}, 32'h0);
            tick(); #2;
        end                                                    // cycle 26
        check("c26_arvalid", {31'h0, ic_arvalid}, 32'h1);
        check("c26_araddr", ic_araddr, 32'h0000_1000);
        check("c26_cache_ena", {31'h0, ic_cache_ena}, 32'h1);
        tick(); tick(); #2;                                    // cycle 28
        check("c28_id_pc", id_pc, 32'h8000_1000);
        check("c28_id_inst", id_inst, 32'hDEAD_AEEF);
        check("c28_id_adel", {31'h0, id_adel}, 32'h0);

        // Redirect in the same cycle as the response.
        tick(); redirect = 1'b1; redirect_pc = 32'h9000_0000;  // cycle 29
        tick(); redirect = 1'b0; #2;                           // cycle 30
        check("c30_id_valid", {31'h0, id_valid}, 32'h0);
        check("c30_arvalid", {31'h0, ic_arvalid}, 32'h1);
        check("c30_araddr", ic_araddr, 32'h1000_0000);
        tick(); tick(); redirect = 1'b1; redirect_pc = 32'h8000_0002; #2;  // cycle 32
        check("c32_id_pc", id_pc, 32'h9000_0000);
        check("c32_id_inst", id_inst, 32'hCEAD_BEEF);

        // Misaligned target: one address-error entry, then fetch halts.
        tick(); redirect = 1'b0;                               // cycle 33
        tick(); #2;                                            // cycle 34
        check("c34_id_valid", {31'h0, id_valid}, 32'h1);
        check("c34_id_adel", {31'h0, id_adel}, 32'h1);
        check("c34_id_pc", id_pc, 32'h8000_0002);
        check("c34_id_inst", id_inst, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick(); #2;
            check("halt_arvalid", {31'h0, ic_arvalid}, 32'h0);
        end                                                    // cycle 39

        // Redirect out of halt to the top of the address space; pc wraps.
        tick(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;  // cycle 40
        tick(); redirect = 1'b0; #2;                           // cycle 41
        check("c41_arvalid", {31'h0, ic_arvalid}, 32'h1);
        check("c41_araddr", ic_araddr, 32'hFFFF_FFFC);
        tick(); tick(); #2;                                    // cycle 43
        check("c43_id_pc", id_pc, 32'hFFFF_FFFC);
        check("c43_araddr", ic_araddr, 32'h0000_0000);
        lat_cfg = 5;

        // Reset while waiting on a response.
        tick(); rst = 1'b0;                                    // cycle 44
        tick(); #2;                                            // cycle 45
        check_reset_values();
        lat_cfg = 1;
        tick(); rst = 1'b1; #2;                                // cycle 46
        check("c46_arvalid", {31'h0, ic_arvalid}, 32'h1);
        check("c46_araddr", ic_araddr, 32'h1FC0_0000);
        tick(); tick(); #2;                                    // cycle 48
        check("c48_id_pc", id_pc, 32'hBFC0_0000);

        // Irregular decode backpressure; the model follows every cycle.
        for (int i = 0; i < 24; i++) begin
            tick();
            id_ready = (i % 3 != 0);
        end
        id_ready = 1'b1;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
